// File: rtl/multu_hilo_unit.sv
// Unsigned WIDTH x WIDTH shift-add multiplier with HI/LO result registers.
// One start per IDLE cycle, WIDTH iterations in RUN, and one DONE cycle that
// commits the product. hilo_out serves MFHI/MFLO reads combinationally.
module multu_hilo_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             multuOp,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [1:0]       hilo_sel,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state: start latch, one shift-add step per RUN cycle, HI/LO commit in DONE.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                // Requests are only honoured here, so a start while busy is dropped.
                if (multuOp) begin
                    mcand_d  = {{WIDTH{1'b0}}, dataA};
                    mplier_d = dataB;
                    prod_d   = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                // No early exit on zero operands: latency is fixed.
                if (count_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                hi_d    = prod_q[PW-1:WIDTH];
                lo_d    = prod_q[WIDTH-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset discards any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Read mux: HI on 01, LO on 10; the ALU/shifter codes read as zero.
    always_comb begin
        case (hilo_sel)
            2'b01:   hilo_out = hi_q;
            2'b10:   hilo_out = lo_q;
            default: hilo_out = '0;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit: latency, results, ignored restarts,
// async reset mid-multiply, back-to-back throughput and zero operands.
module tb_multu_hilo_unit;

    logic        clk;
    logic        rst;
    logic        multuOp;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [1:0]  hilo_sel;
    logic [31:0] hilo_out;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    multu_hilo_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .multuOp (multuOp),
        .dataA   (dataA),
        .dataB   (dataB),
        .hilo_sel(hilo_sel),
        .hilo_out(hilo_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done; lat = edges after the start edge, -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; multuOp = 1'b0; dataA = '0; dataB = '0; hilo_sel = 2'b01;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++;
        if (hilo_out !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 0", hilo_out); end
        hilo_sel = 2'b10; #1;
        tests++;
        if (hilo_out !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want 0", hilo_out); end
    endtask

    task automatic test_basic();
        int busy_cnt;
        int lat;
        int extra;
        multuOp = 1'b1; dataA = 32'd3; dataB = 32'd5;
        tick();
        multuOp = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        tests++;
        if (lat != 33) begin fails++; $display("FAIL basic_latency: got %0d want 33", lat); end
        tests++;
        if (busy_cnt != 33) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 33", busy_cnt); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        hilo_sel = 2'b01; #1;
        tests++;
        if (hilo_out !== 32'd0) begin fails++; $display("FAIL basic_hi: got %h want 0", hilo_out); end
        hilo_sel = 2'b10; #1;
        tests++;
        if (hilo_out !== 32'd15) begin fails++; $display("FAIL basic_lo: got %h want f", hilo_out); end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) extra++;
        end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL basic_single_pulse: got %0d extra want 0", extra); end
    endtask

    task automatic test_max();
        int lat;
        int hold_bad;
        hilo_sel = 2'b10;
        multuOp = 1'b1; dataA = 32'hFFFFFFFF; dataB = 32'hFFFFFFFF;
        tick();
        multuOp = 1'b0;
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (hilo_out !== 32'd15) hold_bad++;
            tick();
        end
        tests++;
        if (hold_bad != 0) begin fails++; $display("FAIL max_lo_held_during_run: got %0d bad want 0", hold_bad); end
        wait_done(lat);
        tests++;
        if (lat != 23) begin fails++; $display("FAIL max_latency: got %0d want 23", lat); end
        hilo_sel = 2'b01; #1;
        tests++;
        if (hilo_out !== 32'hFFFFFFFE) begin fails++; $display("FAIL max_hi: got %h want fffffffe", hilo_out); end
        hilo_sel = 2'b10; #1;
        tests++;
        if (hilo_out !== 32'h00000001) begin fails++; $display("FAIL max_lo: got %h want 00000001", hilo_out); end
        hilo_sel = 2'b00; #1;
        tests++;
        if (hilo_out !== 32'h0) begin fails++; $display("FAIL max_sel00: got %h want 0", hilo_out); end
        hilo_sel = 2'b11; #1;
        tests++;
        if (hilo_out !== 32'h0) begin fails++; $display("FAIL max_sel11: got %h want 0", hilo_out); end
        tick();
    endtask

    task automatic test_ignore_restart();
        int pulses;
        multuOp = 1'b1; dataA = 32'h12345678; dataB = 32'h9ABCDEF0;
        tick();
        multuOp = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 5 || i == 20) begin
                multuOp = 1'b1; dataA = 32'h0000_0011; dataB = 32'h0000_0022;
            end else begin
                multuOp = 1'b0; dataA = 32'hDEAD_BEEF; dataB = 32'hCAFE_F00D;
            end
            tick();
            if (done) pulses++;
        end
        multuOp = 1'b0;
        tests++;
        if (pulses != 1) begin fails++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
        hilo_sel = 2'b01; #1;
        tests++;
        if (hilo_out !== 32'h0B00EA4E) begin fails++; $display("FAIL ignore_hi: got %h want 0b00ea4e", hilo_out); end
        hilo_sel = 2'b10; #1;
        tests++;
        if (hilo_out !== 32'h242D2080) begin fails++; $display("FAIL ignore_lo: got %h want 242d2080", hilo_out); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL ignore_idle_after: got %b want 0", busy); end
    endtask

    task automatic test_async_reset();
        int lat;
        int pulses;
        multuOp = 1'b1; dataA = 32'd7; dataB = 32'd9;
        tick();
        multuOp = 1'b0;
        wait_done(lat);
        hilo_sel = 2'b10; #1;
        tests++;
        if (hilo_out !== 32'd63) begin fails++; $display("FAIL rst_preload_lo: got %h want 3f", hilo_out); end
        tick();
        multuOp = 1'b1; dataA = 32'd100; dataB = 32'd200;
        tick();
        multuOp = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        #1;
        tests++;
        if (hilo_out !== 32'h0) begin fails++; $display("FAIL rst_async_lo: got %h want 0", hilo_out); end
        hilo_sel = 2'b01; #1;
        tests++;
        if (hilo_out !== 32'h0) begin fails++; $display("FAIL rst_async_hi: got %h want 0", hilo_out); end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL rst_async_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        tests++;
        if (pulses != 0) begin fails++; $display("FAIL rst_no_resume: got %0d active cycles want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        int low_cnt;
        int lo_bad;
        int lat;
        hilo_sel = 2'b10;
        multuOp = 1'b1; dataA = 32'd2; dataB = 32'd21;
        low_cnt = 0;
        lo_bad = 0;
        for (int c = 1; c <= 110; c++) begin
            tick();
            if (done) begin
                done_at.push_back(c);
                if (hilo_out !== 32'd42) lo_bad++;
            end
            if (done_at.size() == 1 && !busy) low_cnt++;
        end
        multuOp = 1'b0;
        tests++;
        if (done_at.size() != 3) begin
            fails++; $display("FAIL b2b_pulse_count: got %0d want 3", done_at.size());
        end else begin
            tests++;
            if (done_at[1] - done_at[0] != 34 || done_at[2] - done_at[1] != 34) begin
                fails++;
                $display("FAIL b2b_period: got %0d,%0d want 34,34",
                         done_at[1] - done_at[0], done_at[2] - done_at[1]);
            end
        end
        tests++;
        if (lo_bad != 0) begin fails++; $display("FAIL b2b_lo: got %0d bad reads want 0", lo_bad); end
        tests++;
        if (low_cnt != 1) begin fails++; $display("FAIL b2b_busy_gap: got %0d want 1", low_cnt); end
        wait_done(lat);
        tick();
    endtask

    task automatic test_zero();
        int lat;
        multuOp = 1'b1; dataA = 32'd0; dataB = 32'hFFFFFFFF;
        tick();
        multuOp = 1'b0;
        wait_done(lat);
        tests++;
        if (lat != 33) begin fails++; $display("FAIL zero_latency: got %0d want 33", lat); end
        hilo_sel = 2'b01; #1;
        tests++;
        if (hilo_out !== 32'h0) begin fails++; $display("FAIL zero_hi: got %h want 0", hilo_out); end
        hilo_sel = 2'b10; #1;
        tests++;
        if (hilo_out !== 32'h0) begin fails++; $display("FAIL zero_lo: got %h want 0", hilo_out); end
        hilo_sel = 2'b11; #1;
        tests++;
        if (hilo_out !== 32'h0) begin fails++; $display("FAIL zero_sel11: got %h want 0", hilo_out); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_max();
        test_ignore_restart();
        test_async_reset();
        test_back_to_back();
        test_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
